sel_scan_mux: RTL and testbench



---
 rtl/sel_scan_mux.sv | 116 +++++++++++
 tb/tb_sel_scan_mux.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sel_scan_mux.sv
// Registered N-channel selector: manual active-low one-hot select or prescaled auto scan.
// Drives a data bus plus an active-low digit-select bus; shows a default word when disabled.
module sel_scan_mux #(
  parameter int unsigned N   = 8,
  parameter int unsigned W   = 24,
  parameter int unsigned DIV = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           mode_i,
  input  logic [N-1:0]   sel_in_i,
  input  logic [N*W-1:0] din_i,
  input  logic [W-1:0]   dflt_i,
  output logic [W-1:0]   dout_o,
  output logic [N-1:0]   sel_out_o,
  output logic           err_o,
  output logic           scan_wrap_o
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned PcW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);
  localparam logic [PcW-1:0]  PcLast  = PcW'(DIV - 1);

  logic [W-1:0]    chan [N];
  logic [W-1:0]    dout_d, dout_q;
  logic [N-1:0]    sel_d, sel_q;
  logic            err_d, err_q;
  logic            wrap_d, wrap_q;
  logic [IdxW-1:0] idx_d, idx_q;
  logic [PcW-1:0]  pc_d, pc_q;

  logic [N-1:0]    sel_inv;
  logic            sel_valid;
  logic [IdxW-1:0] man_idx;

  always_comb begin
    for (int k = 0; k < int'(N); k++) begin
      chan[k] = din_i[k*W +: W];
    end
  end

  // Valid code: exactly one low bit, i.e. the inverted code is a nonzero power of two.
  always_comb begin
    sel_inv   = ~sel_in_i;
    sel_valid = (sel_inv != '0) && ((sel_inv & (sel_inv - N'(1))) == '0);
    man_idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel_inv[k]) begin
        man_idx = IdxW'(k);
      end
    end
  end

  always_comb begin
    dout_d = dflt_i;
    sel_d  = '1;
    err_d  = 1'b0;
    wrap_d = 1'b0;
    idx_d  = idx_q;
    pc_d   = pc_q;
    if (en_i) begin
      if (!mode_i) begin
        idx_d = '0;
        pc_d  = '0;
        if (sel_valid) begin
          dout_d = chan[man_idx];
          sel_d  = sel_in_i;
        end else begin
          dout_d = chan[0];
          sel_d  = ~N'(1);
          err_d  = 1'b1;
        end
      end else begin
        dout_d = chan[idx_q];
        sel_d  = ~(N'(1) << idx_q);
        if (pc_q == PcLast) begin
          pc_d = '0;
          if (idx_q == IdxLast) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          pc_d = pc_q + PcW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q <= '0;
      sel_q  <= '1;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      idx_q  <= '0;
      pc_q   <= '0;
    end else begin
      dout_q <= dout_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
      idx_q  <= idx_d;
      pc_q   <= pc_d;
    end
  end

  assign dout_o      = dout_q;
  assign sel_out_o   = sel_q;
  assign err_o       = err_q;
  assign scan_wrap_o = wrap_q;

endmodule

// File: tb/tb_sel_scan_mux.sv
// Directed bench for sel_scan_mux: DIV=4 and DIV=1 instances share one stimulus stream.
module tb_sel_scan_mux;

  localparam int unsigned N = 8;
  localparam int unsigned W = 24;

  logic           clk = 1'b0;
  logic           rst, en, mode;
  logic [N-1:0]   sel_in;
  logic [N*W-1:0] din;
  logic [W-1:0]   dflt;

  logic [W-1:0] dout4, dout1;
  logic [N-1:0] sel4, sel1;
  logic         err4, err1, wrap4, wrap1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sel_scan_mux #(.N(N), .W(W), .DIV(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_in_i(sel_in),
    .din_i(din), .dflt_i(dflt), .dout_o(dout4), .sel_out_o(sel4), .err_o(err4),
    .scan_wrap_o(wrap4)
  );

  sel_scan_mux #(.N(N), .W(W), .DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_in_i(sel_in),
    .din_i(din), .dflt_i(dflt), .dout_o(dout1), .sel_out_o(sel1), .err_o(err1),
    .scan_wrap_o(wrap1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Check the DIV=4 instance's full output set.
  task automatic chk4(input string tag, input logic [W-1:0] d, input logic [N-1:0] s,
                      input logic e, input logic w);
    chk({tag, ".dout"}, 32'(dout4), 32'(d));
    chk({tag, ".sel"},  32'(sel4),  32'(s));
    chk({tag, ".err"},  32'(err4),  32'(e));
    chk({tag, ".wrap"}, 32'(wrap4), 32'(w));
  endtask

  function automatic logic [W-1:0] chval(input int k);
    return W'(k * 16 + 1);
  endfunction

  function automatic logic [N-1:0] selv(input int k);
    return ~(N'(1) << k);
  endfunction

  initial begin
    for (int k = 0; k < int'(N); k++) din[k*W +: W] = chval(k);
    dflt   = 24'hABCDEF;
    sel_in = 8'hFF;
    rst = 1'b1; en = 1'b1; mode = 1'b1;

    // Reset
    step(); step();
    chk4("reset", 24'h0, 8'hFF, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk4("rst_release", 24'h000001, 8'hFE, 1'b0, 1'b0);

    // Manual valid
    mode = 1'b0; sel_in = 8'hFB;
    step();
    chk4("man_fb", 24'h000021, 8'hFB, 1'b0, 1'b0);
    sel_in = 8'h7F;
    step();
    chk4("man_7f", 24'h000071, 8'h7F, 1'b0, 1'b0);

    // Manual invalid
    sel_in = 8'hFF;
    step();
    chk4("man_ff", 24'h000001, 8'hFE, 1'b1, 1'b0);
    sel_in = 8'hFC;
    step();
    chk4("man_fc", 24'h000001, 8'hFE, 1'b1, 1'b0);
    sel_in = 8'hEF;
    step();
    chk4("man_ef", 24'h000041, 8'hEF, 1'b0, 1'b0);

    // Disable in both modes
    en = 1'b0;
    step();
    chk4("dis_m0", 24'hABCDEF, 8'hFF, 1'b0, 1'b0);
    mode = 1'b1;
    step();
    chk4("dis_m1", 24'hABCDEF, 8'hFF, 1'b0, 1'b0);

    // Scan from channel 0: two full rounds on both instances
    en = 1'b1;
    for (int t = 1; t <= 64; t++) begin
      step();
      chk("scan4.dout", 32'(dout4), 32'(chval(((t - 1) / 4) % 8)));
      chk("scan4.sel",  32'(sel4),  32'(selv(((t - 1) / 4) % 8)));
      chk("scan4.wrap", 32'(wrap4), 32'((t % 32) == 0));
      chk("scan1.dout", 32'(dout1), 32'(chval((t - 1) % 8)));
      chk("scan1.sel",  32'(sel1),  32'(selv((t - 1) % 8)));
      chk("scan1.wrap", 32'(wrap1), 32'((t % 8) == 0));
    end

    // Advance to idx=3, pc=1; channel 3 has been shown for one cycle
    for (int t = 1; t <= 13; t++) step();
    chk4("pre_hold", 24'h000031, 8'hF7, 1'b0, 1'b0);
    en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      step();
      chk("hold.dout", 32'(dout4), 32'(24'hABCDEF));
    end
    en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      chk4("resume3", 24'h000031, 8'hF7, 1'b0, 1'b0);
    end
    step();
    chk4("resume4", 24'h000041, 8'hEF, 1'b0, 1'b0);

    // data change mid-dwell shows after one cycle
    din[4*W +: W] = 24'h123456;
    step();
    chk4("din_live", 24'h123456, 8'hEF, 1'b0, 1'b0);
    din[4*W +: W] = chval(4);

    // Reset priority over en=0
    rst = 1'b1; en = 1'b0; mode = 1'b1;
    step();
    chk4("rst_prio", 24'h0, 8'hFF, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b1;
    for (int t = 1; t <= 21; t++) step();
    chk4("at_idx5", 24'h000051, 8'hDF, 1'b0, 1'b0);

    // Mode 1->0 takes effect immediately, re-entering scan restarts at 0
    mode = 1'b0; sel_in = 8'hFD;
    step();
    chk4("to_man", 24'h000011, 8'hFD, 1'b0, 1'b0);
    mode = 1'b1;
    step();
    chk4("rescan", 24'h000001, 8'hFE, 1'b0, 1'b0);
    step();
    chk4("rescan2", 24'h000001, 8'hFE, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
